// File: rtl/nsa_pkg.sv
// nsa_pkg: shared definitions for the nibble-serial adder.
//   state_t : controller states (IDLE, RUN, DONE)
//   NIBBLE  : digit width processed per RUN cycle
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE = 4;

endpackage : nsa_pkg

// File: rtl/adder4.sv
// adder4: combinational 4-bit ripple adder used once per RUN cycle.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   cout : carry out of bit 3
//   c3   : carry into bit 3 (needed for signed overflow on the top nibble)
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    always_comb begin
        logic c;
        c    = cin;
        s    = '0;
        c3   = 1'b0;
        cout = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            if (i == 3) begin
                c3 = c;
            end
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule : adder4

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands plus carry-in, one
// nibble per clock, least-significant nibble first.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   A, B, Cin           : operands, latched on the accept edge
//   out_valid/out_ready : result handshake (valid only in DONE)
//   Sum, Cout, Ovf      : result, unsigned carry-out, signed overflow
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned NNIB = WIDTH / NIBBLE;
    localparam int unsigned IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    state_t state, state_nx;

    logic [WIDTH-1:0] a_r, b_r;
    logic [IDXW-1:0]  idx;
    logic             carry;

    logic [3:0] nib_a, nib_b, nib_s;
    logic       nib_co, nib_c3;
    logic       last_nib;

    // ------------------------------------------------------------------
    // Controller: state register + next-state/handshake decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign last_nib = (idx == LAST_IDX);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Nibble select: constant-index mux keeps part-selects static
    // ------------------------------------------------------------------
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned k = 0; k < NNIB; k++) begin
            if (idx == IDXW'(k)) begin
                nib_a = a_r[k*NIBBLE +: NIBBLE];
                nib_b = b_r[k*NIBBLE +: NIBBLE];
            end
        end
    end

    adder4 u_adder4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_co),
        .c3   (nib_c3)
    );

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= A;
                        b_r   <= B;
                        carry <= Cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    // Only the nibble being processed is rewritten; the rest
                    // of Sum keeps its previous contents until overwritten.
                    for (int unsigned k = 0; k < NNIB; k++) begin
                        if (idx == IDXW'(k)) begin
                            Sum[k*NIBBLE +: NIBBLE] <= nib_s;
                        end
                    end
                    carry <= nib_co;
                    if (last_nib) begin
                        idx  <= '0;
                        Cout <= nib_co;
                        Ovf  <= nib_c3 ^ nib_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : nibble_serial_adder
